// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, boot address and fetch FSM states.
package core_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Output register plus one-entry skid register between the fetch pipe and decode.
module fetch_buffer
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               skid_valid
);

  logic [XLEN-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // Skid holds the older word, so it must drain first to keep program order.
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_pc     <= skid_pc;
        out_instr  <= skid_instr;
        skid_valid <= in_valid;
        if (in_valid) begin
          skid_pc    <= in_pc;
          skid_instr <= in_instr;
        end
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_pc    <= in_pc;
          out_instr <= in_instr;
        end
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
      skid_pc    <= in_pc;
      skid_instr <= in_instr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC/FSM, one-cycle-latency imem interface, redirect handling.
// Optional FETCH_MISALIGN_CHECK_EN adds a FAULT state for misaligned redirect targets.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [XLEN-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic               fault_valid,
  output logic [XLEN-1:0]    fault_pc
`endif
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_pc_q;
  logic            pend_q;
  logic            skid_valid;
  logic            consume;
  logic [1:0]      occupancy;
  logic            issue;

  assign consume   = out_valid & out_ready;
  assign occupancy = {1'b0, pend_q} + {1'b0, out_valid} + {1'b0, skid_valid};
  // A slot freed by this cycle's consume may be reused by a new request.
  assign issue     = (state_q == ST_RUN) && !redirect_valid
                     && ((occupancy - {1'b0, consume}) < 2'd2);
  assign imem_en   = issue;
  assign imem_addr = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      pend_q    <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_valid <= 1'b0;
      fault_pc    <= '0;
`endif
    end else begin
      pend_q <= issue;
      if (issue) begin
        pend_pc_q <= pc_q;
        pc_q      <= pc_q + 32'd4;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_valid) begin
        if (redirect_pc[1:0] != 2'b00) begin
          state_q     <= ST_FAULT;
          fault_valid <= 1'b1;
          fault_pc    <= redirect_pc;
        end else begin
          state_q     <= ST_RUN;
          fault_valid <= 1'b0;
          pc_q        <= redirect_pc;
        end
      end else if (state_q == ST_BOOT) begin
        state_q <= ST_RUN;
      end
`else
      if (redirect_valid) begin
        pc_q <= redirect_pc & 32'hFFFF_FFFC;
      end
      if (state_q == ST_BOOT) begin
        state_q <= ST_RUN;
      end
`endif
    end
  end

  // The response landing in a redirect cycle belongs to the abandoned path.
  fetch_buffer u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .in_valid   (pend_q & ~redirect_valid),
    .in_pc      (pend_pc_q),
    .in_instr   (imem_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .skid_valid (skid_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: imem model, expected-PC scoreboard, immediate assertions.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_data = 32'hDEAD_BEEF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fault_valid;
  logic [31:0] fault_pc;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fault_valid    (fault_valid),
    .fault_pc       (fault_pc)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // Synchronous instruction memory: data for a request appears the next cycle.
  always @(posedge clk) begin
    imem_data <= imem_en ? word_of(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scores the handshake that will occur at the coming rising edge.
  task automatic sb();
    logic [31:0] pc;
    if (rst_n && out_valid && out_ready && !redirect_valid) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_out: observed pc=%h expected=none", out_pc);
      end
      if (exp_q.size() > 0) begin
        pc = exp_q.pop_front();
        chk("out_pc", out_pc, pc);
        chk("out_instr", out_instr, word_of(pc));
      end
    end
  endtask

  task automatic next_neg();
    sb();
    @(negedge clk);
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < max_cyc) begin
      next_neg();
      n++;
    end
    out_ready = 1'b0;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Redirect with decode stalled, check restart timing, then stream n words.
  task automatic do_redirect(input logic [31:0] tgt, input logic [31:0] exp_pc, input int n);
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    #1;
    chk("redir_en_low", imem_en, 1'b0);
    next_neg();
    redirect_valid = 1'b0;
    #1;
    chk("redir_issue_en", imem_en, 1'b1);
    chk("redir_issue_addr", imem_addr, exp_pc);
    chk("redir_valid_r1", out_valid, 1'b0);
    next_neg();
    chk("redir_valid_r2", out_valid, 1'b0);
    next_neg();
    chk("redir_valid_r3", out_valid, 1'b1);
    chk("redir_first_pc", out_pc, exp_pc);
    chk("redir_addr_ahead", imem_addr, exp_pc + 32'd8);
    chk("redir_full_en", imem_en, 1'b0);
    push_seq(exp_pc, n);
    drain(10 * n + 10);
  endtask

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset values, then release and stream from RESET_PC
    @(negedge clk);
    chk("rst_en", imem_en, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    push_seq(RST_PC, 8);
    rst_n = 1'b1;
    next_neg();
    for (int k = 1; k <= 10; k++) begin
      chk("boot_en", imem_en, 1'b1);
      chk("boot_addr", imem_addr, RST_PC + 32'(4 * (k - 1)));
      chk("boot_valid", out_valid, (k >= 3) ? 1'b1 : 1'b0);
      next_neg();
    end

    // Decode stalls for 5 cycles: buffer fills to two, nothing lost
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_en", imem_en, 1'b0);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_pc", out_pc, RST_PC + 32'd32);
      next_neg();
    end
    push_seq(RST_PC + 32'd32, 8);
    drain(40);

    // Redirect with output and skid both full
    for (int i = 0; i < 3; i++) next_neg();
    do_redirect(32'h8000_0100, 32'h8000_0100, 8);

    // Redirect with a response in flight
    do_redirect(32'h8000_0400, 32'h8000_0400, 4);

    // Address wrap at the top of the space
    do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8, 5);

`ifdef FETCH_MISALIGN_CHECK_EN
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    #1;
    chk("fault_redir_en", imem_en, 1'b0);
    next_neg();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    #1;
    chk("fault_valid", fault_valid, 1'b1);
    chk("fault_pc", fault_pc, 32'h8000_0102);
    for (int i = 0; i < 3; i++) begin
      chk("fault_en", imem_en, 1'b0);
      chk("fault_out_valid", out_valid, 1'b0);
      next_neg();
    end
    do_redirect(32'h8000_0200, 32'h8000_0200, 4);
    chk("fault_cleared", fault_valid, 1'b0);
`else
    do_redirect(32'h8000_0302, 32'h8000_0300, 4);
`endif

    // Reset mid-stream with a word presented and a response pending
    chk("pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_en", imem_en, 1'b0);
    chk("midrst_out_pc", out_pc, 32'd0);
    chk("midrst_out_instr", out_instr, 32'd0);
    chk("midrst_addr", imem_addr, RST_PC);
    next_neg();
    next_neg();
    rst_n = 1'b1;
    push_seq(RST_PC, 4);
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
